// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: one outstanding request at a time, branch redirect with
// stale-response discard. Optional macro FETCH_TIMEOUT_EN bounds WAIT and raises fetch_error.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] imem_instruction,
  input  logic        imem_valid,
  output logic        imem_request,
  output logic [31:0] imem_address,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instruction_valid,
  output logic        fetch_error
);

  typedef enum logic [1:0] {S_IDLE, S_REQUEST, S_WAIT, S_HOLD} state_t;

  state_t      state, state_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] addr_q, addr_n;
  logic [31:0] instruction_n, pc_n;
  logic [31:0] target;
  logic        discard, discard_n;
  logic        valid_n;

  if (TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign target       = branch_target & 32'hFFFF_FFFC;
  assign imem_request = (state == S_REQUEST);
  // Address is live during the request cycle and then frozen for the rest of the fetch.
  assign imem_address = imem_request ? fetch_pc : addr_q;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_count, wait_count_n;
  logic          fetch_error_n;
  logic          timeout;

  assign timeout = (state == S_WAIT) && !imem_valid &&
                   (wait_count == CW'(TIMEOUT_CYCLES - 1));
`else
  assign fetch_error = 1'b0;
`endif

  // NOTE: every variable written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n       = state;
    fetch_pc_n    = fetch_pc;
    addr_n        = addr_q;
    discard_n     = discard;
    instruction_n = instruction;
    pc_n          = pc;
    valid_n       = instruction_valid;
`ifdef FETCH_TIMEOUT_EN
    wait_count_n  = wait_count;
    fetch_error_n = fetch_error;
`endif

    case (state)
      S_IDLE: state_n = S_REQUEST;
      S_REQUEST: begin
        addr_n = fetch_pc;
        if (branch_taken) begin
          fetch_pc_n = target;
          valid_n    = 1'b0;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (branch_taken) begin
          fetch_pc_n = target;
          if (imem_valid) begin
            discard_n = 1'b0;
            state_n   = S_REQUEST;
          end else begin
            discard_n = 1'b1;
          end
        end else if (imem_valid) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = S_REQUEST;
          end else begin
            instruction_n = imem_instruction;
            pc_n          = fetch_pc;
            valid_n       = 1'b1;
            state_n       = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (branch_taken) begin
          fetch_pc_n = target;
          valid_n    = 1'b0;
          state_n    = S_REQUEST;
        end else if (!stall) begin
          fetch_pc_n = fetch_pc + 32'd4;
          valid_n    = 1'b0;
          state_n    = S_REQUEST;
        end
      end
      default: state_n = S_IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if (state == S_REQUEST) begin
      wait_count_n = '0;
    end else if (state == S_WAIT && !imem_valid) begin
      wait_count_n = wait_count + 1'b1;
    end
    // A timeout re-issues whatever fetch_pc holds, including a redirect taken this cycle.
    if (timeout) begin
      fetch_error_n = 1'b1;
      discard_n     = 1'b0;
      state_n       = S_REQUEST;
    end
`endif
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      fetch_pc          <= RESET_PC;
      addr_q            <= RESET_PC;
      discard           <= 1'b0;
      instruction       <= '0;
      pc                <= RESET_PC;
      instruction_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      wait_count        <= '0;
      fetch_error       <= 1'b0;
`endif
    end else begin
      state             <= state_n;
      fetch_pc          <= fetch_pc_n;
      addr_q            <= addr_n;
      discard           <= discard_n;
      instruction       <= instruction_n;
      pc                <= pc_n;
      instruction_valid <= valid_n;
`ifdef FETCH_TIMEOUT_EN
      wait_count        <= wait_count_n;
      fetch_error       <= fetch_error_n;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed literal scenarios plus randomized traffic
// against a transaction-level model; the timeout scenario runs when FETCH_TIMEOUT_EN is defined.
module tb_instruction_fetch_unit;

  localparam logic [31:0] PC1 = 32'hFFFF_FFFC;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] imem_instruction = '0;
  logic        imem_valid = 1'b0;

  logic        imem_request, instruction_valid, fetch_error;
  logic [31:0] imem_address, instruction, pc;
  logic        d1_imem_request, d1_instruction_valid, d1_fetch_error;
  logic [31:0] d1_imem_address, d1_instruction, d1_pc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  instruction_fetch_unit dut0 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_instruction(imem_instruction),
    .imem_valid(imem_valid), .imem_request(imem_request), .imem_address(imem_address),
    .instruction(instruction), .pc(pc), .instruction_valid(instruction_valid),
    .fetch_error(fetch_error)
  );

  instruction_fetch_unit #(.RESET_PC(PC1)) dut1 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_instruction(imem_instruction),
    .imem_valid(imem_valid), .imem_request(d1_imem_request), .imem_address(d1_imem_address),
    .instruction(d1_instruction), .pc(d1_pc), .instruction_valid(d1_instruction_valid),
    .fetch_error(d1_fetch_error)
  );

`ifdef FETCH_TIMEOUT_EN
  logic        d2_imem_request, d2_instruction_valid, d2_fetch_error;
  logic [31:0] d2_imem_address, d2_instruction, d2_pc;

  instruction_fetch_unit #(.TIMEOUT_CYCLES(4)) dut2 (
    .clock(clock), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_instruction(imem_instruction),
    .imem_valid(1'b0), .imem_request(d2_imem_request), .imem_address(d2_imem_address),
    .instruction(d2_instruction), .pc(d2_pc), .instruction_valid(d2_instruction_valid),
    .fetch_error(d2_fetch_error)
  );
`endif

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 50) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  bit          pending, req_s, rand_lat, spurious_en;
  logic [31:0] p_addr, addr_s;
  int          p_due;

  task automatic mem_update();
    if (imem_valid) pending = 1'b0;
    if (req_s) begin
      pending = 1'b1;
      p_addr  = addr_s;
      p_due   = rand_lat ? int'($urandom_range(1, 4)) : 2;
    end
    imem_valid       = 1'b0;
    imem_instruction = $urandom;
    if (pending) begin
      p_due--;
      if (p_due == 0) begin
        imem_valid       = 1'b1;
        imem_instruction = mem_word(p_addr);
      end
    end else if (spurious_en && $urandom_range(0, 9) == 0) begin
      imem_valid = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
    mem_update();
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    stall        = 1'b0;
    branch_taken = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
  endtask

  // ---------------- transaction-level model of dut0 ----------------
  bit          m_idle, m_req, m_out, m_disc, m_hold;
  logic [31:0] m_fetch, m_out_addr, m_hold_pc;

  always @(posedge clock) begin
    logic [31:0] t;
    t = branch_target & 32'hFFFF_FFFC;
    if (reset) begin
      m_idle = 1; m_req = 0; m_out = 0; m_disc = 0; m_hold = 0; m_fetch = 32'h0;
    end else if (m_idle) begin
      m_idle = 0; m_req = 1;
    end else if (m_req) begin
      if (branch_taken) m_fetch = t;
      else begin m_req = 0; m_out = 1; m_out_addr = m_fetch; end
    end else if (m_out) begin
      if (branch_taken) begin
        m_fetch = t;
        if (imem_valid) begin m_out = 0; m_req = 1; m_disc = 0; end
        else m_disc = 1;
      end else if (imem_valid) begin
        m_out = 0;
        if (m_disc) begin m_disc = 0; m_req = 1; end
        else begin m_hold = 1; m_hold_pc = m_fetch; end
      end
    end else if (m_hold) begin
      if (branch_taken) begin m_fetch = t; m_hold = 0; m_req = 1; end
      else if (!stall) begin m_fetch = m_fetch + 32'd4; m_hold = 0; m_req = 1; end
    end
  end

  // ---------------- compare process and event logs ----------------
  bit          chk_en, log_en;
  logic [31:0] req_log[$], d1_log[$], pc_log[$];

  always @(negedge clock) begin
    req_s  = imem_request;
    addr_s = imem_address;
    if (chk_en) begin
      check("request", 32'(imem_request), 32'(m_req));
      if (m_req) check("request_addr", imem_address, m_fetch);
      else if (m_out) check("wait_addr", imem_address, m_out_addr);
      check("instruction_valid", 32'(instruction_valid), 32'(m_hold));
      if (m_hold) begin
        check("pc", pc, m_hold_pc);
        check("instruction", instruction, mem_word(m_hold_pc));
      end
      check("fetch_error", 32'(fetch_error), 32'h0);
    end
    if (log_en) begin
      if (imem_request) req_log.push_back(imem_address);
      if (d1_imem_request) d1_log.push_back(d1_imem_address);
      if (instruction_valid) pc_log.push_back(pc);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] exp_seq[3];
    logic [31:0] exp_d1[2];
    logic [31:0] held, seen_addr;
    bit          found, stale;
    int          since;

    exp_seq = '{32'h0, 32'h4, 32'h8};
    exp_d1  = '{32'hFFFF_FFFC, 32'h0};

    do_reset();
    chk_en = 1'b1;
    check("rst_request", 32'(imem_request), 32'h0);
    check("rst_address", imem_address, 32'h0);
    check("rst_pc", pc, 32'h0);
    check("rst_instruction", instruction, 32'h0);
    check("rst_valid", 32'(instruction_valid), 32'h0);
    check("rst_d1_address", d1_imem_address, 32'hFFFF_FFFC);
    check("rst_d1_pc", d1_pc, 32'hFFFF_FFFC);

    // Sequential fetch with a fixed 2-cycle memory, no stall.
    req_log.delete(); d1_log.delete(); pc_log.delete();
    log_en = 1'b1;
    repeat (20) cycle();
    log_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("seq_req_addr", (i < req_log.size()) ? req_log[i] : 32'hDEAD_BEEF, exp_seq[i]);
      check("seq_valid_pc", (i < pc_log.size()) ? pc_log[i] : 32'hDEAD_BEEF, exp_seq[i]);
    end
    for (int i = 0; i < 2; i++)
      check("wrap_req_addr", (i < d1_log.size()) ? d1_log[i] : 32'hDEAD_BEEF, exp_d1[i]);

    // Stall for 5 cycles while holding pc 0x8.
    do_reset();
    stall = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 80 && !found; i++) begin
      cycle();
      if (instruction_valid && pc == 32'h8) begin found = 1'b1; stall = 1'b1; end
      else stall = !instruction_valid;
    end
    check("hold_reached", 32'(found), 32'h1);
    held = instruction;
    check("hold_word", held, mem_word(32'h8));
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("hold_valid", 32'(instruction_valid), 32'h1);
      check("hold_pc", pc, 32'h8);
      check("hold_instruction", instruction, held);
      check("hold_no_request", 32'(imem_request), 32'h0);
    end
    stall = 1'b0;

    // Branch to 0x2A while waiting for 0x4.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (imem_request && imem_address == 32'h4) found = 1'b1;
    end
    check("req4_seen", 32'(found), 32'h1);
    cycle();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_002A;
    cycle();
    branch_taken = 1'b0;
    stale = 1'b0; found = 1'b0; seen_addr = 32'hDEAD_BEEF;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (instruction_valid && pc == 32'h4) stale = 1'b1;
      if (imem_request) begin found = 1'b1; seen_addr = imem_address; end
    end
    check("redirect_no_stale", 32'(stale), 32'h0);
    check("redirect_addr", seen_addr, 32'h28);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (instruction_valid) found = 1'b1;
    end
    check("redirect_delivered", 32'(found), 32'h1);
    check("redirect_pc", pc, 32'h28);

    // Branch to 0x40 in the same cycle the response arrives.
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle();
      if (imem_request) found = 1'b1;
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cycle();
      if (imem_valid) found = 1'b1;
    end
    check("same_cycle_resp_seen", 32'(found), 32'h1);
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0040;
    cycle();
    branch_taken = 1'b0;
    check("same_cycle_no_valid", 32'(instruction_valid), 32'h0);
    check("same_cycle_request", 32'(imem_request), 32'h1);
    check("same_cycle_addr", imem_address, 32'h40);

`ifdef FETCH_TIMEOUT_EN
    // Silent memory on dut2 (TIMEOUT_CYCLES=4).
    do_reset();
    cycle();
    check("to_first_request", 32'(d2_imem_request), 32'h1);
    check("to_first_addr", d2_imem_address, 32'h0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("to_waiting_no_error", 32'(d2_fetch_error), 32'h0);
      check("to_waiting_no_request", 32'(d2_imem_request), 32'h0);
    end
    cycle();
    check("to_error_set", 32'(d2_fetch_error), 32'h1);
    check("to_reissue", 32'(d2_imem_request), 32'h1);
    check("to_reissue_addr", d2_imem_address, 32'h0);
    do_reset();
    check("to_error_cleared", 32'(d2_fetch_error), 32'h0);
`endif

    // Randomized traffic: variable latency, stalls, branches, stray responses, resets.
    do_reset();
    rand_lat    = 1'b1;
    spurious_en = 1'b1;
    since       = 0;
    repeat (3000) begin
      cycle();
      since++;
      stall         = ($urandom_range(0, 99) < 40);
      branch_taken  = (since > 1) && ($urandom_range(0, 99) < 7);
      branch_target = $urandom;
      if ($urandom_range(0, 999) < 3) begin
        do_reset();
        since = 0;
      end
    end
    branch_taken = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
